gated_event_counter: RTL and testbench

Receive-side consumer of the 1 Hz gate toggle produced by the board timer. Counts rising edges of an asynchronous detector pulse line (`event_in`) inside each gate window and hands the completed count downstream with a one-cycle valid strobe. Sits between the discriminator input pin and the coincidence and display logic. Includes a watchdog that flags a lost gate.

---
 rtl/gated_event_counter_pkg.sv | 12 +
 rtl/edge_sync.sv | 28 ++
 rtl/gated_event_counter.sv | 112 +++++++++++
 tb/tb_gated_event_counter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/gated_event_counter_pkg.sv
// Shared definitions for the gated event counter: FSM encoding and the
// system clock rate used to derive the default watchdog period.
package gated_event_counter_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer followed by a rising-edge detector for one
// asynchronous detector channel.
module edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_p;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_p  <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_p  <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_p;

endmodule

// File: rtl/gated_event_counter.sv
// Counts synchronized event edges between gate transitions, publishes each
// closed window with a one-cycle strobe, and flags a lost gate.
module gated_event_counter
  import gated_event_counter_pkg::*;
#(
  parameter int COUNT_W        = 16,
  parameter int TIMEOUT_CYCLES = (CLK_HZ / 5) * 6,
  parameter int TMO_W          = 26
) (
  input  logic               sys_clk,
  input  logic               reset,
  input  logic               event_in,
  input  logic               gate_toggle,
  output logic [COUNT_W-1:0] count_out,
  output logic               count_valid,
  output logic               overflow,
  output logic               gate_lost,
  output logic               counting
);

  localparam logic [COUNT_W-1:0] ACC_MAX = {COUNT_W{1'b1}};
  localparam logic [TMO_W-1:0]   WD_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t             r_state;
  logic [COUNT_W-1:0] r_acc;
  logic               r_sat;
  logic [TMO_W-1:0]   r_wd;
  logic               r_gate_q;
  logic               w_ev_rise;
  logic               w_gate_edge;
  logic               w_acc_max;

  function automatic logic [COUNT_W-1:0] sat_add(input logic [COUNT_W-1:0] a,
                                                 input logic inc);
    return (inc && (a != ACC_MAX)) ? a + COUNT_W'(1) : a;
  endfunction

  edge_sync u_edge_sync (
    .i_clk   (sys_clk),
    .i_reset (reset),
    .i_async (event_in),
    .o_rise  (w_ev_rise)
  );

  // Loading the live level during reset keeps reset release edge-free.
  always_ff @(posedge sys_clk) begin
    r_gate_q <= gate_toggle;
  end

  assign w_gate_edge = gate_toggle ^ r_gate_q;
  assign w_acc_max   = (r_acc == ACC_MAX);

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_wd        <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      overflow    <= 1'b0;
      gate_lost   <= 1'b0;
      counting    <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_acc <= '0;
          r_sat <= 1'b0;
          r_wd  <= '0;
          if (w_gate_edge) begin
            r_state  <= ST_COUNT;
            counting <= 1'b1;
          end else begin
            counting <= 1'b0;
          end
        end
        ST_COUNT: begin
          // Gate edge takes priority over expiry; a coincident event closes with the window.
          if (w_gate_edge) begin
            count_out   <= sat_add(r_acc, w_ev_rise);
            overflow    <= r_sat | (w_ev_rise & w_acc_max);
            count_valid <= 1'b1;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_wd        <= '0;
          end else if (r_wd == WD_LAST) begin
            r_state   <= ST_IDLE;
            counting  <= 1'b0;
            gate_lost <= 1'b1;
            r_acc     <= '0;
            r_sat     <= 1'b0;
            r_wd      <= '0;
          end else begin
            r_wd  <= r_wd + TMO_W'(1);
            r_acc <= sat_add(r_acc, w_ev_rise);
            if (w_ev_rise && w_acc_max) begin
              r_sat <= 1'b1;
            end else begin
              r_sat <= r_sat;
            end
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          counting <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gated_event_counter.sv
// Directed bench for gated_event_counter: table of windows plus hand-written
// corner sequences, with expected window results checked through a queue.
module tb_gated_event_counter;

  logic       clk;
  logic       reset;
  logic       event_in;
  logic       gate_toggle;
  logic [3:0] count_out;
  logic       count_valid;
  logic       overflow;
  logic       gate_lost;
  logic       counting;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int pushes = 0;
  int last_cnt = 0;
  int last_ovf = 0;

  typedef struct {
    int n;
    int hi;
    int lo;
    int exp_cnt;
    int exp_ovf;
  } vec_t;

  typedef struct {
    int cnt;
    int ovf;
  } exp_t;

  vec_t tbl [7];
  exp_t q [$];

  gated_event_counter #(
    .COUNT_W        (4),
    .TIMEOUT_CYCLES (100),
    .TMO_W          (26)
  ) dut (
    .sys_clk     (clk),
    .reset       (reset),
    .event_in    (event_in),
    .gate_toggle (gate_toggle),
    .count_out   (count_out),
    .count_valid (count_valid),
    .overflow    (overflow),
    .gate_lost   (gate_lost),
    .counting    (counting)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every strobe must match the oldest expected window result.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (count_valid) begin
      strobes++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=%0d expected=none at %0t", count_out, $time);
      end else begin
        e = q.pop_front();
        check("strobe_count", int'(count_out), e.cnt);
        check("strobe_ovf", int'(overflow), e.ovf);
      end
    end
  end

  task automatic pulse(input int hi, input int lo);
    event_in = 1'b1;
    repeat (hi) @(negedge clk);
    event_in = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic toggle_gate(input bit closes, input int cnt, input int ovf);
    exp_t e;
    @(negedge clk);
    if (closes) begin
      e.cnt = cnt;
      e.ovf = ovf;
      q.push_back(e);
      pushes++;
      last_cnt = cnt;
      last_ovf = ovf;
    end
    gate_toggle = ~gate_toggle;
    @(posedge clk);
    #1;
    check("valid_latency", int'(count_valid), int'(closes));
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    event_in = 1'b0;
    gate_toggle = 1'b0;
    tbl[0] = '{5, 3, 3, 5, 0};
    tbl[1] = '{2, 3, 3, 2, 0};
    tbl[2] = '{20, 2, 2, 15, 1};
    tbl[3] = '{3, 3, 3, 3, 0};
    tbl[4] = '{15, 2, 2, 15, 0};
    tbl[5] = '{16, 2, 2, 15, 1};
    tbl[6] = '{0, 3, 3, 0, 0};

    repeat (3) @(negedge clk);
    check("rst_count_out", int'(count_out), 0);
    check("rst_valid", int'(count_valid), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_gate_lost", int'(gate_lost), 0);
    check("rst_counting", int'(counting), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Events before the first gate edge are discarded.
    repeat (3) pulse(3, 3);
    check("idle_counting", int'(counting), 0);
    toggle_gate(1'b0, 0, 0);
    check("counting_rise", int'(counting), 1);

    for (int i = 0; i < 7; i++) begin
      for (int p = 0; p < tbl[i].n; p++) pulse(tbl[i].hi, tbl[i].lo);
      check("held_count", int'(count_out), last_cnt);
      check("held_ovf", int'(overflow), last_ovf);
      toggle_gate(1'b1, tbl[i].exp_cnt, tbl[i].exp_ovf);
    end

    // Watchdog: window opened by the last toggle, no gate activity for 100 cycles.
    repeat (99) @(posedge clk);
    #1;
    check("wd_before_lost", int'(gate_lost), 0);
    check("wd_before_counting", int'(counting), 1);
    @(posedge clk);
    #1;
    check("wd_lost", int'(gate_lost), 1);
    check("wd_counting", int'(counting), 0);
    @(negedge clk);
    repeat (2) pulse(3, 3);
    toggle_gate(1'b0, 0, 0);
    check("resume_counting", int'(counting), 1);
    check("lost_sticky", int'(gate_lost), 1);
    repeat (4) pulse(3, 3);
    toggle_gate(1'b1, 4, 0);
    check("lost_sticky2", int'(gate_lost), 1);

    // Event edge lands in the same cycle as the gate edge.
    repeat (2) pulse(3, 3);
    event_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    e.cnt = 3;
    e.ovf = 0;
    q.push_back(e);
    pushes++;
    last_cnt = 3;
    last_ovf = 0;
    gate_toggle = ~gate_toggle;
    @(posedge clk);
    #1;
    check("coinc_valid", int'(count_valid), 1);
    @(negedge clk);
    event_in = 1'b0;
    repeat (3) @(negedge clk);
    pulse(3, 3);
    toggle_gate(1'b1, 1, 0);

    // Reset mid-window with gate held high through release.
    repeat (7) pulse(3, 3);
    reset = 1'b1;
    gate_toggle = 1'b1;
    repeat (3) @(negedge clk);
    check("mid_rst_count_out", int'(count_out), 0);
    check("mid_rst_overflow", int'(overflow), 0);
    check("mid_rst_gate_lost", int'(gate_lost), 0);
    check("mid_rst_counting", int'(counting), 0);
    reset = 1'b0;
    last_cnt = 0;
    last_ovf = 0;
    repeat (20) @(negedge clk);
    check("post_rst_counting", int'(counting), 0);
    check("post_rst_count_out", int'(count_out), 0);
    toggle_gate(1'b0, 0, 0);
    pulse(3, 3);
    toggle_gate(1'b1, 1, 0);

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("strobe_total", strobes, pushes);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
